// File: rtl/dm_arbiter.sv
// Arbiter for the shared single-port data memory: the com port in load/dump phases, round-robin cores in run.
// Each access takes ISSUE then COMPLETE to cover the memory's one-cycle synchronous read latency.
module dm_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  status,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_wr_en,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_grant,
    output logic [NUM_CORES-1:0]        core_rvalid,
    output logic [DATA_W-1:0]           core_rdata,
    input  logic                        com_req,
    input  logic                        com_wr_en,
    input  logic [ADDR_W-1:0]           com_addr,
    input  logic [DATA_W-1:0]           com_data_in,
    output logic                        com_ack,
    output logic [DATA_W-1:0]           com_data_out,
    output logic [ADDR_W-1:0]           DM_addr,
    output logic [DATA_W-1:0]           DM_data_in,
    output logic                        DM_write_en,
    input  logic [DATA_W-1:0]           DM_out,
    output logic                        busy
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, COMPLETE} state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     last, last_d;
    logic [IDX_W-1:0]     owner, owner_d;
    logic                 owner_com, owner_com_d;
    logic [IDX_W-1:0]     pick, cand;
    logic                 pick_valid;
    logic                 can_start, start_com, start_core;
    logic [ADDR_W-1:0]    dm_addr_d;
    logic [DATA_W-1:0]    dm_data_d;
    logic                 dm_we_d, ack_d, busy_d;
    logic [NUM_CORES-1:0] grant_d, rvalid_d;
    logic [DATA_W-1:0]    core_hold, com_hold;

    // Round-robin search starting just after the last granted core.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        cand       = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            int j;
            j = int'(last) + k;
            if (j >= NUM_CORES) j = j - NUM_CORES;
            cand = IDX_W'(j);
            if (!pick_valid && core_req[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    assign can_start  = (state == IDLE) || (state == COMPLETE);
    assign start_com  = can_start && com_req && ((status == 2'b00) || (status == 2'b10));
    assign start_core = can_start && (status == 2'b01) && pick_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last         <= IDX_W'(NUM_CORES - 1);
            owner        <= '0;
            owner_com    <= 1'b0;
            DM_addr      <= '0;
            DM_data_in   <= '0;
            DM_write_en  <= 1'b0;
            core_grant   <= '0;
            core_rvalid  <= '0;
            com_ack      <= 1'b0;
            busy         <= 1'b0;
            core_hold    <= '0;
            com_hold     <= '0;
        end else begin
            state        <= state_nxt;
            last         <= last_d;
            owner        <= owner_d;
            owner_com    <= owner_com_d;
            DM_addr      <= dm_addr_d;
            DM_data_in   <= dm_data_d;
            DM_write_en  <= dm_we_d;
            core_grant   <= grant_d;
            core_rvalid  <= rvalid_d;
            com_ack      <= ack_d;
            busy         <= busy_d;
            if (|core_rvalid) core_hold <= DM_out;
            if (com_ack)      com_hold  <= DM_out;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, COMPLETE: state_nxt = (start_com || start_core) ? ISSUE : IDLE;
            ISSUE:          state_nxt = COMPLETE;
            default:        state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs, loaded on the edge entering ISSUE or COMPLETE.
    always_comb begin
        dm_addr_d   = DM_addr;
        dm_data_d   = DM_data_in;
        dm_we_d     = 1'b0;
        grant_d     = '0;
        rvalid_d    = '0;
        ack_d       = 1'b0;
        busy_d      = (state_nxt != IDLE);
        owner_d     = owner;
        owner_com_d = owner_com;
        last_d      = last;
        if (start_com) begin
            dm_addr_d   = com_addr;
            dm_data_d   = com_data_in;
            dm_we_d     = com_wr_en && (status == 2'b00);
            owner_com_d = 1'b1;
        end else if (start_core) begin
            dm_addr_d     = core_addr[pick*ADDR_W +: ADDR_W];
            dm_data_d     = core_wdata[pick*DATA_W +: DATA_W];
            dm_we_d       = core_wr_en[pick];
            grant_d[pick] = 1'b1;
            owner_d       = pick;
            owner_com_d   = 1'b0;
            last_d        = pick;
        end
        if (state == ISSUE) begin
            if (owner_com) ack_d = 1'b1;
            else           rvalid_d[owner] = 1'b1;
        end
    end

    // Memory data arrives during COMPLETE, so it is passed through then and held afterwards.
    assign core_rdata   = (|core_rvalid) ? DM_out : core_hold;
    assign com_data_out = com_ack ? DM_out : com_hold;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a small synchronous-read memory model.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  status;
    logic [3:0]  core_req, core_wr_en, core_grant, core_rvalid;
    logic [63:0] core_addr, core_wdata;
    logic [15:0] core_rdata;
    logic        com_req, com_wr_en, com_ack;
    logic [15:0] com_addr, com_data_in, com_data_out;
    logic [15:0] DM_addr, DM_data_in, DM_out;
    logic        DM_write_en, busy;

    logic [15:0] mem [0:255];
    int total = 0;
    int bad   = 0;

    dm_arbiter #(.NUM_CORES(4), .DATA_W(16), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .status(status),
        .core_req(core_req), .core_wr_en(core_wr_en), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_grant(core_grant), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata), .com_req(com_req), .com_wr_en(com_wr_en),
        .com_addr(com_addr), .com_data_in(com_data_in), .com_ack(com_ack),
        .com_data_out(com_data_out), .DM_addr(DM_addr), .DM_data_in(DM_data_in),
        .DM_write_en(DM_write_en), .DM_out(DM_out), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    end

    // Read-first synchronous memory.
    always @(posedge clk) begin
        if (DM_write_en) mem[DM_addr[7:0]] <= DM_data_in;
        DM_out <= mem[DM_addr[7:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] st, input logic [3:0] creq,
                                 input logic creq_com, input logic cwr, input logic [15:0] caddr,
                                 input logic [15:0] cdata);
        status      = st;
        core_req    = creq;
        com_req     = creq_com;
        com_wr_en   = cwr;
        com_addr    = caddr;
        com_data_in = cdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        core_wr_en = 4'b0000;
        core_addr  = {16'h0023, 16'h0022, 16'h0021, 16'h0020};
        core_wdata = {16'hD333, 16'hD222, 16'hD111, 16'hD000};
        applyStimulus(2'b00, 4'b0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick(); tick();
        checkOutput("rst_busy",  32'(busy), 0);
        checkOutput("rst_grant", 32'(core_grant), 0);
        checkOutput("rst_we",    32'(DM_write_en), 0);
        checkOutput("rst_addr",  32'(DM_addr), 0);
        rst_n = 1'b1;

        // Load: com write while all cores request
        applyStimulus(2'b00, 4'b1111, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        tick();
        checkOutput("load_we",    32'(DM_write_en), 1);
        checkOutput("load_addr",  32'(DM_addr), 32'h0010);
        checkOutput("load_data",  32'(DM_data_in), 32'hBEEF);
        checkOutput("load_busy",  32'(busy), 1);
        checkOutput("load_grant", 32'(core_grant), 0);
        com_req = 1'b0;
        tick();
        checkOutput("load_ack",    32'(com_ack), 1);
        checkOutput("load_we_off", 32'(DM_write_en), 0);
        checkOutput("load_rvalid", 32'(core_rvalid), 0);
        tick();
        checkOutput("load_ack_off", 32'(com_ack), 0);
        checkOutput("load_idle",    32'(busy), 0);

        // Run: continuous requests from all cores, back-to-back round robin
        status = 2'b01;
        tick();
        for (int n = 0; n < 6; n++) begin
            checkOutput("rr_grant", 32'(core_grant), 32'(1 << (n % 4)));
            checkOutput("rr_addr",  32'(DM_addr), 32'h0020 + 32'(n % 4));
            if (n == 5) core_req = 4'b0101;
            tick();
            checkOutput("rr_rvalid", 32'(core_rvalid), 32'(1 << (n % 4)));
            checkOutput("rr_rdata",  32'(core_rdata), 32'h1020 + 32'(n % 4));
            tick();
        end

        // Skip: last=1, core_req=0101 -> core 2 then core 0
        checkOutput("skip_grant2", 32'(core_grant), 32'b0100);
        tick();
        checkOutput("skip_rvalid2", 32'(core_rvalid), 32'b0100);
        checkOutput("skip_rdata2",  32'(core_rdata), 32'h1022);
        tick();
        checkOutput("skip_grant0", 32'(core_grant), 32'b0001);
        checkOutput("hold_rdata",  32'(core_rdata), 32'h1022);
        core_req = 4'b1000;
        tick();
        checkOutput("skip_rvalid0", 32'(core_rvalid), 32'b0001);
        tick();
        checkOutput("sw_grant3", 32'(core_grant), 32'b1000);

        // Phase switch to load while core 3 is in ISSUE; com reads back 0x0010
        applyStimulus(2'b00, 4'b1111, 1'b1, 1'b0, 16'h0010, 16'h0000);
        tick();
        checkOutput("sw_rvalid3", 32'(core_rvalid), 32'b1000);
        checkOutput("sw_rdata3",  32'(core_rdata), 32'h1023);
        tick();
        checkOutput("sw_grant_none", 32'(core_grant), 0);
        checkOutput("sw_com_busy",   32'(busy), 1);
        checkOutput("sw_com_we",     32'(DM_write_en), 0);
        com_req = 1'b0;
        tick();
        checkOutput("sw_com_ack",   32'(com_ack), 1);
        checkOutput("sw_com_data",  32'(com_data_out), 32'hBEEF);
        checkOutput("sw_core_hold", 32'(core_rdata), 32'h1023);
        tick();
        checkOutput("sw_idle",     32'(busy), 0);
        checkOutput("sw_com_hold", 32'(com_data_out), 32'hBEEF);

        // Dump: requested write is forced to a read
        applyStimulus(2'b10, 4'b1111, 1'b1, 1'b1, 16'h0010, 16'h1234);
        tick();
        checkOutput("dump_we",   32'(DM_write_en), 0);
        checkOutput("dump_busy", 32'(busy), 1);
        com_req = 1'b0;
        tick();
        checkOutput("dump_ack",  32'(com_ack), 1);
        checkOutput("dump_data", 32'(com_data_out), 32'hBEEF);
        tick();

        // Halt: nothing is served
        applyStimulus(2'b11, 4'b1111, 1'b1, 1'b0, 16'h0010, 16'h0000);
        for (int n = 0; n < 3; n++) begin
            tick();
            checkOutput("halt_busy",  32'(busy), 0);
            checkOutput("halt_grant", 32'(core_grant), 0);
        end
        com_req = 1'b0;

        // Reset asserted during an ISSUE drops the access
        status = 2'b01;
        tick();
        checkOutput("prerst_grant", 32'(core_grant), 32'b0001);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_grant", 32'(core_grant), 0);
        checkOutput("arst_busy",  32'(busy), 0);
        checkOutput("arst_addr",  32'(DM_addr), 0);
        checkOutput("arst_rdata", 32'(core_rdata), 0);
        for (int n = 0; n < 3; n++) begin
            tick();
            checkOutput("arst_rvalid", 32'(core_rvalid), 0);
        end
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_grant", 32'(core_grant), 32'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port data memory between NUM_CORES processor cores and the communication (host/UART loader) port.
- The global 2-bit status selects the phase: 00 load (com writes), 01 run (cores arbitrated round-robin), 10 dump (com reads).
- Sequences each access as ISSUE then COMPLETE, to match the memory's one-cycle synchronous read latency.
- Replaces purely combinational steering with registered, handshaked ownership of the memory port.

Parameters:
- NUM_CORES, 4, number of core requesters (2..8).
- DATA_W, 16, memory data width.
- ADDR_W, 16, memory address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- status  in  2  phase: 00 load, 01 run, 10 dump, 11 halt.
- core_req  in  NUM_CORES  per-core access request; level, held until grant.
- core_wr_en  in  NUM_CORES  per-core write (1) or read (0).
- core_addr  in  NUM_CORES*ADDR_W  packed addresses; core i occupies bits [i*ADDR_W +: ADDR_W].
- core_wdata  in  NUM_CORES*DATA_W  packed write data, same packing.
- core_grant  out  NUM_CORES  one-hot, one-cycle pulse in ISSUE.
- core_rvalid  out  NUM_CORES  one-hot, one-cycle pulse in COMPLETE (reads and writes).
- core_rdata  out  DATA_W  read data, shared by all cores; qualified by core_rvalid.
- com_req  in  1  com access request; level.
- com_wr_en  in  1  com write (1) or read (0).
- com_addr  in  ADDR_W  com address.
- com_data_in  in  DATA_W  com write data.
- com_ack  out  1  one-cycle pulse in COMPLETE.
- com_data_out  out  DATA_W  com read data, valid with com_ack.
- DM_addr  out  ADDR_W  memory address.
- DM_data_in  out  DATA_W  memory write data.
- DM_write_en  out  1  memory write strobe.
- DM_out  in  DATA_W  memory read data; valid one cycle after DM_addr.
- busy  out  1  high while in ISSUE or COMPLETE.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - All outputs go to 0.
  - The round-robin pointer last goes to NUM_CORES-1, so core 0 has first priority.
  - Any transaction in flight is dropped; no ack or rvalid is issued for it.
- All outputs are registered.
- States:
  - IDLE: status is evaluated here and at the end of COMPLETE, never mid-transaction.
    - 00: if com_req, latch the com request and go to ISSUE.
    - 10: if com_req, latch com with the write forced to 0 and go to ISSUE.
    - 01: pick the first requesting core, searching from last+1 with modulo-NUM_CORES wrap; latch it and go to ISSUE. If no core requests, stay in IDLE.
    - 11: stay in IDLE; no grants issued.
    - com_req is ignored in 01 and 11; core_req is ignored in 00, 10 and 11.
  - ISSUE (1 cycle):
    - DM_addr and DM_data_in carry the latched request.
    - DM_write_en equals the latched write bit.
    - For a core, core_grant[i] pulses and last is set to i.
    - Go to COMPLETE.
  - COMPLETE (1 cycle):
    - DM_write_en is 0.
    - For a core: core_rvalid[i]=1 and core_rdata=DM_out.
    - For com: com_ack=1 and com_data_out=DM_out.
    - Data outputs hold their value until the next COMPLETE.
    - Then evaluate as in IDLE: a pending request goes directly to ISSUE (back-to-back); otherwise go to IDLE.
- Throughput is one access per 2 cycles.
- Read latency, request sampled to rvalid or ack, is 2 cycles.
- Requester rules:
  - Address, data and write bit must be stable from req assertion until grant (cores) or ack (com).
  - Drop req in the cycle after rvalid or ack to avoid a repeat access.
  - A core that keeps req high competes again; round-robin guarantees every other requester is served first.
- A status change during ISSUE or COMPLETE takes effect only after COMPLETE; the in-flight access finishes normally.
- Addresses are used as given; no range checking and no wrap logic beyond ADDR_W.

Test Plan:
- Reset: rst_n low for 3 cycles during an ISSUE -> all outputs 0, state IDLE; after release, core 0 wins when all cores request.
- Load: status=00, com write addr 0x0010 data 0xBEEF -> DM_write_en=1 with DM_addr=0x0010 and DM_data_in=0xBEEF in ISSUE, then com_ack pulse; core_req=1111 meanwhile -> no grant.
- Run fairness: status=01, all 4 cores request reads continuously -> grants in order 0,1,2,3,0 at 2-cycle spacing; each rvalid arrives 1 cycle after its grant with core_rdata=DM_out.
- Round-robin skip: last=1, core_req=0101 -> core 2 is granted next, then core 0.
- Dump: status=10, com_wr_en=1, com_addr=0x0010 -> DM_write_en stays 0; com_data_out=0xBEEF with com_ack.
- Phase switch: status changes 01->00 while core 3 is in ISSUE -> core 3 gets rvalid; the next grant goes to com only; status=11 -> busy stays 0.
